// File: rtl/sine_pkg.sv
// Shared widths, types and sign helper for the accumulating sine generator.
// Build option SINE_SYNC_OUT_EN is consumed by sine_accum_gen.
package sine_pkg;

    localparam int ADDR_W = 9;
    localparam int DIFF_W = 16;
    localparam int SMP_W  = 17;

    localparam logic [ADDR_W-1:0] ADDR_LAST = 9'd511;

    typedef logic [1:0] quad_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } state_t;

    function automatic logic [SMP_W-1:0] apply_sign(
        input logic [DIFF_W-1:0] mag,
        input logic              neg
    );
        logic [SMP_W-1:0] v;
        v = {1'b0, mag};
        return neg ? ((~v) + 17'd1) : v;
    endfunction

endpackage

// File: rtl/sine_tick_div.sv
// Sample-rate divider: counts enabled cycles, emits tick on the DIV-th one.
// Holds its count while disabled; clear returns it to zero.
module sine_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sine_accum_gen.sv
// Integrates quarter-wave table differences into a 4-quadrant signed sine.
// Define SINE_SYNC_OUT_EN to add the period-end sync_out flag.
module sine_accum_gen
    import sine_pkg::*;
#(
    parameter int                DIV     = 4,
    parameter logic [DIFF_W-1:0] SAT_MAX = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     phase_clr,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [SMP_W-1:0]  out_sample,
`ifdef SINE_SYNC_OUT_EN
    output logic                     sync_out,
`endif
    output logic [ADDR_W-1:0]        rom_adrs,
    input  logic [DIFF_W-1:0]        rom_diff
);

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_addr;
    quad_t             r_quad;
    logic [DIFF_W-1:0] r_mag;
    logic              r_valid;
    logic [SMP_W-1:0]  r_sample;

    logic              w_tick;
    logic              w_div_en;
    logic              w_free;
    logic              w_upd;
    logic              w_load;
    logic [DIFF_W:0]   w_sum;
    logic [DIFF_W-1:0] w_mag_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    quad_t             w_quad_nx;

    assign w_div_en   = (r_state == RUN) && run;
    assign w_free     = !r_valid || out_ready;
    assign w_load     = w_upd && !phase_clr;
    assign rom_adrs   = r_addr;
    assign out_valid  = r_valid;
    assign out_sample = r_sample;

    sine_tick_div #(
        .DIV(DIV)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_div_en),
        .i_clr (phase_clr),
        .o_tick(w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_upd      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (run) w_state_nx = RUN;
            end
            RUN: begin
                if (!run) begin
                    w_state_nx = IDLE;
                end else if (w_tick) begin
                    if (w_free) w_upd = 1'b1;
                    else        w_state_nx = STALL;
                end
            end
            STALL: begin
                if (!run) begin
                    w_state_nx = IDLE;
                end else if (out_ready) begin
                    w_upd      = 1'b1;
                    w_state_nx = RUN;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Rising quadrants add and saturate; falling quadrants subtract down to 0
    always_comb begin
        w_sum     = {1'b0, r_mag} + {1'b0, rom_diff};
        w_mag_nx  = r_mag;
        w_addr_nx = r_addr;
        w_quad_nx = r_quad;
        if (!r_quad[0]) begin
            w_mag_nx = (w_sum > {1'b0, SAT_MAX}) ? SAT_MAX : w_sum[DIFF_W-1:0];
            if (r_addr == ADDR_LAST) w_quad_nx = r_quad + 2'd1;
            else                     w_addr_nx = r_addr + ADDR_W'(1);
        end else begin
            w_mag_nx = (r_mag > rom_diff) ? (r_mag - rom_diff) : '0;
            if (r_addr == '0) begin
                w_quad_nx = r_quad + 2'd1;
                w_mag_nx  = '0;
            end else begin
                w_addr_nx = r_addr - ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || phase_clr) begin
            r_addr <= '0;
            r_quad <= '0;
            r_mag  <= '0;
        end else if (w_upd) begin
            r_addr <= w_addr_nx;
            r_quad <= w_quad_nx;
            r_mag  <= w_mag_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_sample <= '0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_sample <= apply_sign(w_mag_nx, r_quad[1]);
        end else if (out_ready) begin
            r_valid  <= 1'b0;
        end
    end

`ifdef SINE_SYNC_OUT_EN
    logic r_sync;

    assign sync_out = r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 1'b0;
        end else if (w_load) begin
            r_sync <= (r_quad == 2'd3) && (r_addr == '0);
        end else if (out_ready) begin
            r_sync <= 1'b0;
        end
    end
`endif

endmodule
